// File: rtl/round_controller.sv
// Round controller for a match-the-target game: LFSR target generation, round timer, lives and score.
// Optional build macro ROUND_CTRL_SPEEDUP_EN shortens the round reload value after every win.
module round_controller #(
  parameter int unsigned ROUND_TICKS = 500,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic       is_equal,
  output logic [7:0] number,
  output logic [7:0] score,
  output logic [1:0] lives_left,
  output logic [9:0] time_left,
  output logic       round_win,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, OVER} state_t;

  localparam logic [9:0] TICKS_INIT = 10'(ROUND_TICKS);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [4:0] HOLD_GOAL  = 5'(HOLD_CYCLES);

  state_t      state, state_nxt;
  logic        load_second, load_second_nxt;
  logic [3:0]  hold_cnt, hold_nxt;
  logic [7:0]  lfsr;
  logic [7:0]  number_nxt, score_nxt;
  logic [1:0]  lives_nxt;
  logic [9:0]  time_nxt;
  logic        round_win_nxt, game_over_nxt;
  logic [9:0]  reload_val;
  logic        game_start, win, timeout;

  assign game_start = ((state == IDLE) || (state == OVER)) && start;
  assign win        = (state == PLAY) && is_equal && (({1'b0, hold_cnt} + 5'd1) == HOLD_GOAL);
  assign timeout    = (state == PLAY) && tick && (time_left == 10'd1);

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running so the target depends on start timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

`ifdef ROUND_CTRL_SPEEDUP_EN
  localparam logic [9:0] RELOAD_FLOOR = TICKS_INIT >> 2;
  logic [9:0] reload, reload_nxt, reload_shrunk;

  assign reload_shrunk = reload - (reload >> 3);

  always_comb begin
    reload_nxt = reload;
    if (game_start)
      reload_nxt = TICKS_INIT;
    else if (win)
      reload_nxt = (reload_shrunk < RELOAD_FLOOR) ? RELOAD_FLOOR : reload_shrunk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload <= TICKS_INIT;
    else        reload <= reload_nxt;
  end

  assign reload_val = reload;
`else
  assign reload_val = TICKS_INIT;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      load_second <= 1'b0;
      hold_cnt    <= 4'd0;
      number      <= 8'd0;
      score       <= 8'd0;
      lives_left  <= LIVES_INIT;
      time_left   <= 10'd0;
      round_win   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      load_second <= load_second_nxt;
      hold_cnt    <= hold_nxt;
      number      <= number_nxt;
      score       <= score_nxt;
      lives_left  <= lives_nxt;
      time_left   <= time_nxt;
      round_win   <= round_win_nxt;
      game_over   <= game_over_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OVER: if (start) state_nxt = LOAD;
      LOAD:       if (load_second) state_nxt = PLAY;
      PLAY: begin
        if (win)
          state_nxt = LOAD;
        else if (timeout)
          state_nxt = (lives_left == 2'd1) ? OVER : LOAD;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    load_second_nxt = 1'b0;
    hold_nxt        = hold_cnt;
    number_nxt      = number;
    score_nxt       = score;
    lives_nxt       = lives_left;
    time_nxt        = time_left;
    round_win_nxt   = 1'b0;
    game_over_nxt   = game_over;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          score_nxt     = 8'd0;
          lives_nxt     = LIVES_INIT;
          game_over_nxt = 1'b0;
        end
      end
      LOAD: begin
        // Second LOAD cycle lets the comparator see the new number before PLAY
        load_second_nxt = ~load_second;
        if (!load_second) begin
          number_nxt = lfsr;
          time_nxt   = reload_val;
          hold_nxt   = 4'd0;
        end
      end
      PLAY: begin
        hold_nxt = is_equal ? (hold_cnt + 4'd1) : 4'd0;
        if (tick) time_nxt = time_left - 10'd1;
        if (win) begin
          score_nxt     = (score == 8'hFF) ? score : (score + 8'd1);
          round_win_nxt = 1'b1;
        end else if (timeout) begin
          lives_nxt = lives_left - 2'd1;
          if (lives_left == 2'd1) begin
            game_over_nxt = 1'b1;
            time_nxt      = 10'd0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed scenarios plus randomized traffic against a game model.
module tb_round_controller;

  localparam int RT = 8;
  localparam int LV = 3;
  localparam int HC = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_OVER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       is_equal = 1'b0;
  logic [7:0] number;
  logic [7:0] score;
  logic [1:0] lives_left;
  logic [9:0] time_left;
  logic       round_win;
  logic       game_over;

  round_controller #(.ROUND_TICKS(RT), .LIVES(LV), .HOLD_CYCLES(HC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tick       (tick),
    .is_equal   (is_equal),
    .number     (number),
    .score      (score),
    .lives_left (lives_left),
    .time_left  (time_left),
    .round_win  (round_win),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Game model: whole-game bookkeeping with plain integers
  int m_mode, m_load_left, m_lfsr, m_number, m_score, m_lives, m_time;
  int m_win, m_over, m_hold, m_reload;

  function automatic int lfsr_next(input int v);
    return ((v << 1) & 255) | ($countones(v & 'hB8) & 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_load_left = 0; m_lfsr = 'hA5; m_number = 0; m_score = 0;
    m_lives = LV; m_time = 0; m_win = 0; m_over = 0; m_hold = 0; m_reload = RT;
  endtask

  task automatic model_step(input bit s, input bit t, input bit e);
    int cur;
    bit won, tmo;
    cur = m_lfsr;
    m_win = 0;
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (s) begin
          m_score = 0; m_lives = LV; m_over = 0; m_reload = RT;
          m_mode = M_LOAD; m_load_left = 2;
        end
      end
      M_LOAD: begin
        if (m_load_left == 2) begin
          m_number = cur; m_time = m_reload; m_hold = 0; m_load_left = 1;
        end else begin
          m_mode = M_PLAY;
        end
      end
      default: begin
        won = e && (m_hold + 1 == HC);
        tmo = t && (m_time == 1);
        m_hold = e ? m_hold + 1 : 0;
        if (t) m_time = m_time - 1;
        if (won) begin
          if (m_score < 255) m_score = m_score + 1;
          m_win = 1; m_mode = M_LOAD; m_load_left = 2;
`ifdef ROUND_CTRL_SPEEDUP_EN
          m_reload = m_reload - m_reload / 8;
          if (m_reload < RT / 4) m_reload = RT / 4;
`endif
        end else if (tmo) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_mode = M_OVER; m_over = 1; m_time = 0;
          end else begin
            m_mode = M_LOAD; m_load_left = 2;
          end
        end
      end
    endcase
    m_lfsr = lfsr_next(cur);
  endtask

  always @(posedge clk) if (rst_n) model_step(start, tick, is_equal);

  task automatic compare_all();
    check_eq("number", number, m_number);
    check_eq("score", score, m_score);
    check_eq("lives_left", lives_left, m_lives);
    check_eq("time_left", time_left, m_time);
    check_eq("round_win", round_win, m_win);
    check_eq("game_over", game_over, m_over);
  endtask

  task automatic cycle(input bit s, input bit t, input bit e);
    @(negedge clk);
    compare_all();
    start = s; tick = t; is_equal = e;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (m_mode != M_PLAY && n < 12) begin
      cycle(0, 0, 0);
      n++;
    end
    check_eq("reach_play", m_mode, M_PLAY);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    compare_all();
    start = 0; tick = 0; is_equal = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_number", number, 0);
    check_eq("arst_score", score, 0);
    check_eq("arst_lives", lives_left, LV);
    check_eq("arst_time", time_left, 0);
    check_eq("arst_win", round_win, 0);
    check_eq("arst_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv_before, sc_before, wins;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_number", number, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_lives", lives_left, LV);
    check_eq("rst_time", time_left, 0);
    check_eq("rst_over", game_over, 0);
    rst_n = 1'b1;

    // start -> two LOAD cycles -> PLAY with a fresh target
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    check_eq("load_number_nz", (number != 8'd0), 1);
    check_eq("load_time", time_left, RT);
    check_eq("load_lives", lives_left, LV);

    // three matching cycles then a miss: no win
    repeat (3) cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check_eq("nowin_score", score, 0);
    // HOLD_CYCLES matching cycles: win
    repeat (HC) cycle(0, 0, 1);
    cycle(0, 0, 0);
    check_eq("win_pulse", round_win, 1);
    check_eq("win_score", score, 1);
    cycle(0, 0, 0);
    check_eq("win_pulse_off", round_win, 0);

    // final tick coincides with the winning match cycle
    wait_play();
    lv_before = m_lives;
    sc_before = m_score;
    repeat (RT - HC) cycle(0, 1, 0);
    repeat (HC) cycle(0, 1, 1);
    cycle(0, 0, 0);
    check_eq("coincide_win", round_win, 1);
    check_eq("coincide_lives", lives_left, lv_before);
    check_eq("coincide_score", score, sc_before + 1);

    // run out every life; extra ticks in OVER do nothing
    wait_play();
    repeat (LV * (RT + 2) + 12) cycle(0, 1, 0);
    check_eq("over_flag", game_over, 1);
    check_eq("over_time", time_left, 0);
    check_eq("over_lives", lives_left, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check_eq("restart_score", score, 0);
    check_eq("restart_lives", lives_left, LV);
    check_eq("restart_over", game_over, 0);

    // saturate the score and keep winning
    repeat (265 * (HC + 2)) cycle(0, 0, 1);
    wins = 0;
    repeat (10 * (HC + 2)) begin
      cycle(0, 0, 1);
      if (round_win === 1'b1) wins++;
    end
    check_eq("sat_score", score, 255);
    check_eq("sat_pulses", wins, 10);

    // asynchronous reset in the middle of a round
    wait_play();
    repeat (2) cycle(0, 1, 1);
    reset_mid();
    repeat (4) cycle(0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 997 == 500) reset_mid();
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter ROUND_TICKS, default 500, tick pulses per round; legal range 8..1023.
REQ-002 Parameter LIVES, default 3, lives per game; legal range 1..3.
REQ-003 Parameter HOLD_CYCLES, default 4, consecutive is_equal cycles required to win a round; legal range 1..15.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin a new game.
REQ-007 tick  input  1  one-cycle timebase enable; round timer advances only on tick.
REQ-008 is_equal  input  1  registered switch/target match flag from the comparator; one cycle latency from number.
REQ-009 number  output  8  current target value driven to the comparator.
REQ-010 score  output  8  rounds won in current game.
REQ-011 lives_left  output  2  remaining lives.
REQ-012 time_left  output  10  remaining ticks in current round.
REQ-013 round_win  output  1  one-cycle pulse on each won round.
REQ-014 game_over  output  1  high while in OVER.

Function
REQ-015 FSM states IDLE, LOAD, PLAY, OVER; state register plus all outputs are registered.
REQ-016 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every clock in every state; never reaches 0.
REQ-017 IDLE or OVER, start=1 -> score=0, lives_left=LIVES, game_over=0, enter LOAD; start ignored in LOAD and PLAY.
REQ-018 LOAD lasts exactly 2 cycles: cycle 1 latches number<=LFSR, time_left<=reload value, hold counter<=0; cycle 2 flushes the comparator latency; then PLAY.
REQ-019 PLAY: hold counter increments on is_equal=1, clears on is_equal=0; reaching HOLD_CYCLES is a win.
REQ-020 Win: score increments saturating at 255, round_win pulses for exactly 1 cycle, enter LOAD.
REQ-021 PLAY, tick=1: time_left decrements; tick with time_left==1 is a timeout.
REQ-022 Timeout: lives_left decrements; result 0 -> OVER with game_over=1, else LOAD; score unchanged.
REQ-023 Win and timeout in same cycle: win takes priority, lives_left unchanged.
REQ-024 OVER holds number, score, lives_left=0, time_left=0 until start.
REQ-025 tick outside PLAY has no effect; is_equal outside PLAY has no effect.

Reset
REQ-026 rst_n=0 asynchronously forces: state IDLE, number=0, score=0, lives_left=LIVES, time_left=0, round_win=0, game_over=0, hold counter=0, LFSR=8'hA5.
REQ-027 Reset asserted mid-round abandons the round with no win/timeout side effects; release returns to IDLE awaiting start.

Configuration
REQ-028 Macro ROUND_CTRL_SPEEDUP_EN defined: reload value starts at ROUND_TICKS at game start; each win sets reload <= reload - (reload>>3), floored at ROUND_TICKS>>2; timeouts leave reload unchanged.
REQ-029 Macro undefined: reload value is always ROUND_TICKS; no reload register is synthesized.

Verification
REQ-030 Reset release, start pulse -> LOAD 2 cycles, number=8'hA5-derived LFSR value (non-zero), time_left=ROUND_TICKS, lives_left=3, PLAY.
REQ-031 HOLD_CYCLES=4, is_equal high 4 cycles in PLAY -> round_win pulse 1 cycle, score 0->1, LOAD; is_equal high 3 cycles then low -> no win.
REQ-032 ROUND_TICKS=8, LIVES=2, no match, 16 ticks -> lives 2->1->0, game_over=1, time_left=0; further ticks ignored; start -> score=0, lives=2.
REQ-033 Final tick and 4th is_equal cycle coincide -> win, lives unchanged, score+1.
REQ-034 Score 255, win -> score stays 255, round_win still pulses; rst_n low mid-PLAY -> all outputs at reset values same cycle.
REQ-035 With ROUND_CTRL_SPEEDUP_EN, ROUND_TICKS=512: successive wins -> reload 448, 392, 343, ... floored at 128; without macro -> 512 every round.
